// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared constants, state encoding and key-index helper for
//                the 4x4 matrix keypad scanner.
//  Contents    : NUM_ROWS, NUM_COLS, KEY_W, COL_RESET, state_e, key_index()
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 16;

  // Column 0 driven low out of reset
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    EVAL = 1'b1
  } state_e;

  // Bit position of a key in the one-hot code: 4*row + col
  function automatic logic [3:0] key_index(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Bundles the keypad matrix lines and the decoded key outputs.
//  Signals     : row        - keypad rows, active-low (into scanner)
//                col        - column drive, active-low (from scanner)
//                onehot     - debounced one-hot key code
//                key_pulse  - one-cycle strobe on a new nonzero key
//                frame_tick - one-cycle strobe at each frame evaluation
//  Modports    : master - the scanner; slave - keypad / downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic [KEY_W-1:0]    onehot;
  logic                key_pulse;
  logic                frame_tick;

  modport master (
    input  row,
    output col,
    output onehot,
    output key_pulse,
    output frame_tick
  );

  modport slave (
    output row,
    input  col,
    input  onehot,
    input  key_pulse,
    input  frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Resolves each completed scan frame to a single candidate key,
//                counts consecutive identical candidates and publishes the
//                accepted key with a press strobe.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                frame_valid_i   - high for the one cycle a frame is complete
//                frame_i         - raw pressed-key vector of that frame
//                onehot_o        - accepted key (0 = none)
//                key_pulse_o     - one-cycle strobe when onehot_o becomes nonzero
//  Config      : KEYPAD_GHOST_REJECT_EN - multi-key frames resolve to no key;
//                otherwise the lowest set bit wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid_i,
  input  logic [KEY_W-1:0] frame_i,
  output logic [KEY_W-1:0] onehot_o,
  output logic             key_pulse_o
);

  localparam logic [7:0] c_THRESH = 8'(DEBOUNCE_FRAMES);

  logic [KEY_W-1:0] w_candidate;
  logic [KEY_W-1:0] last_q, last_d;
  logic [KEY_W-1:0] onehot_q, onehot_d;
  logic [7:0]       count_q, count_d;
  logic             pulse_q, pulse_d;

`ifdef KEYPAD_GHOST_REJECT_EN
  logic w_multi;
  // x & (x-1) clears the lowest set bit; anything left means two or more keys
  assign w_multi     = (frame_i & (frame_i - KEY_W'(1))) != '0;
  assign w_candidate = w_multi ? '0 : frame_i;
`else
  // x & -x isolates the lowest set bit (and is x itself for 0 or 1 bits set)
  assign w_candidate = frame_i & (~frame_i + KEY_W'(1));
`endif

  always_comb begin
    last_d   = last_q;
    count_d  = count_q;
    onehot_d = onehot_q;
    pulse_d  = 1'b0;
    if (frame_valid_i) begin
      if (w_candidate == last_q) begin
        if (count_q != 8'hFF) begin
          count_d = count_q + 8'd1;
        end
      end else begin
        last_d  = w_candidate;
        count_d = 8'd1;
      end
      if ((count_d >= c_THRESH) && (w_candidate != onehot_q)) begin
        onehot_d = w_candidate;
        pulse_d  = (w_candidate != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= '0;
      count_q  <= '0;
      onehot_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      count_q  <= count_d;
      onehot_q <= onehot_d;
      pulse_q  <= pulse_d;
    end
  end

  assign onehot_o    = onehot_q;
  assign key_pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Scans a 4x4 active-low matrix keypad one column at a time,
//                assembles a full frame of pressed keys and hands it to the
//                debouncer once per frame (4*SCAN_DIV+1 cycles).
//  Ports       : clk, rst - clock, asynchronous active-high reset
//                kp       - keypad_scanner_if.master (row, col, onehot,
//                           key_pulse, frame_tick)
//  Parameters  : SCAN_DIV        - cycles each column is driven (>= 3)
//                DEBOUNCE_FRAMES - identical frames needed to accept (1..255)
//  Config      : KEYPAD_GHOST_REJECT_EN - see keypad_debounce
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int               DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  state_e              state_q, state_d;
  logic [KEY_W-1:0]    frame_q, frame_d;
  logic                w_frame_valid;

  // Row lines are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    frame_d   = frame_q;
    case (state_q)
      SCAN: begin
        if (div_q == c_DIV_LAST) begin
          // Sample on the divider's last cycle so the rows have settled
          for (int r = 0; r < NUM_ROWS; r++) begin
            frame_d[key_index(2'(r), col_idx_q)] = ~row_sync_q[r];
          end
          div_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          col_d     = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
          if (col_idx_q == 2'd3) begin
            state_d = EVAL;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      EVAL: begin
        // Debouncer consumes frame_q this cycle; start the next frame clean
        state_d = SCAN;
        frame_d = '0;
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      div_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= COL_RESET;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
    end
  end

  assign w_frame_valid = (state_q == EVAL);

  keypad_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .frame_valid_i (w_frame_valid),
    .frame_i       (frame_q),
    .onehot_o      (kp.onehot),
    .key_pulse_o   (kp.key_pulse)
  );

  assign kp.col        = col_q;
  assign kp.frame_tick = w_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//                DEBOUNCE_FRAMES=3, 17-cycle frame). A keypad model pulls
//                rows low for pressed keys on the driven column; a
//                frame-level reference model predicts the accepted key.
//  Config      : honours KEYPAD_GHOST_REJECT_EN for multi-key expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- keypad matrix model ----------------
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  rowv;

  always_comb begin
    rowv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp.col[c] && pressed[4*r+c]) rowv[r] = 1'b0;
      end
    end
  end
  assign kp.row = rowv;

  // ---------------- frame-level reference model ----------------
  logic [15:0] m_last   = 16'h0000;
  logic [15:0] m_onehot = 16'h0000;
  int          m_cnt    = 0;
  logic        m_pulse  = 1'b0;

  function automatic logic [15:0] resolve(input logic [15:0] m);
    if ($countones(m) <= 1) return m;
`ifdef KEYPAD_GHOST_REJECT_EN
    return 16'h0000;
`else
    for (int i = 0; i < 16; i++) begin
      if (m[i]) return 16'd1 << i;
    end
    return 16'h0000;
`endif
  endfunction

  task automatic model_step(input logic [15:0] m);
    logic [15:0] cand;
    cand = resolve(m);
    if (cand == m_last) begin
      if (m_cnt < 255) m_cnt++;
    end else begin
      m_last = cand;
      m_cnt  = 1;
    end
    m_pulse = 1'b0;
    if (m_cnt >= DF && cand != m_onehot) begin
      m_onehot = cand;
      m_pulse  = (cand != 16'h0000);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kp.frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no frame_tick expected one within 40 cycles");
    end
  endtask

  // Hold mask for one frame, advance the model, stop just after the EVAL edge
  task automatic do_frame(input logic [15:0] m);
    bit ok;
    pressed = m;
    wait_tick(ok);
    model_step(m);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear_chk();
    @(posedge clk);
    #1;
    check("pulse_one_cycle", {31'd0, kp.key_pulse}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] mask;
    logic [15:0] exp_oh;
    logic        exp_p;
  } vec_t;

  vec_t tbl[28];

  function automatic logic [15:0] rand_mask();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return 16'h0000;
      3:       return (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
      default: return 16'd1 << $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          p;
    logic [3:0]  exp_col;
    logic [15:0] m;
    int          hold;
    bit          ok;
    int          k;

    // press 0x0040 (row1/col2), hold, release
    tbl[0]  = '{16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{16'h0040, 16'h0000, 1'b0};
    tbl[3]  = '{16'h0040, 16'h0000, 1'b0};
    tbl[4]  = '{16'h0040, 16'h0040, 1'b1};
    tbl[5]  = '{16'h0040, 16'h0040, 1'b0};
    tbl[6]  = '{16'h0040, 16'h0040, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0040, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0040, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0000, 1'b0};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0};
    // bounce for 5 frames then hold
    tbl[11] = '{16'h0100, 16'h0000, 1'b0};
    tbl[12] = '{16'h0000, 16'h0000, 1'b0};
    tbl[13] = '{16'h0100, 16'h0000, 1'b0};
    tbl[14] = '{16'h0000, 16'h0000, 1'b0};
    tbl[15] = '{16'h0100, 16'h0000, 1'b0};
    tbl[16] = '{16'h0100, 16'h0000, 1'b0};
    tbl[17] = '{16'h0100, 16'h0100, 1'b1};
    // direct A -> B
    tbl[18] = '{16'h0008, 16'h0100, 1'b0};
    tbl[19] = '{16'h0008, 16'h0100, 1'b0};
    tbl[20] = '{16'h0008, 16'h0008, 1'b1};
    // release, then row0/col0 + row2/col3 together
    tbl[21] = '{16'h0000, 16'h0008, 1'b0};
    tbl[22] = '{16'h0000, 16'h0008, 1'b0};
    tbl[23] = '{16'h0000, 16'h0000, 1'b0};
    tbl[24] = '{16'h0801, 16'h0000, 1'b0};
    tbl[25] = '{16'h0801, 16'h0000, 1'b0};
`ifdef KEYPAD_GHOST_REJECT_EN
    tbl[26] = '{16'h0801, 16'h0000, 1'b0};
    tbl[27] = '{16'h0801, 16'h0000, 1'b0};
`else
    tbl[26] = '{16'h0801, 16'h0001, 1'b1};
    tbl[27] = '{16'h0801, 16'h0001, 1'b0};
`endif

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_col",    {28'd0, kp.col},        32'h0000_000E);
    check("rst_onehot", {16'd0, kp.onehot},     32'd0);
    check("rst_pulse",  {31'd0, kp.key_pulse},  32'd0);
    check("rst_tick",   {31'd0, kp.frame_tick}, 32'd0);

    // ---- idle scanning: column rotation and frame timing ----
    rst = 1'b0;
    for (int j = 0; j < 200; j++) begin
      p       = j % 17;
      exp_col = (p == 16) ? 4'b1110 : ~(4'b0001 << (p / 4));
      check("idle_col",    {28'd0, kp.col},        {28'd0, exp_col});
      check("idle_tick",   {31'd0, kp.frame_tick}, {31'd0, (p == 16)});
      check("idle_onehot", {16'd0, kp.onehot},     32'd0);
      check("idle_pulse",  {31'd0, kp.key_pulse},  32'd0);
      if (kp.frame_tick) model_step(16'h0000);
      @(negedge clk);
    end

    // ---- directed table ----
    for (int i = 0; i < 28; i++) begin
      do_frame(tbl[i].mask);
      check($sformatf("tbl%0d_onehot", i), {16'd0, kp.onehot},    {16'd0, tbl[i].exp_oh});
      check($sformatf("tbl%0d_pulse", i),  {31'd0, kp.key_pulse}, {31'd0, tbl[i].exp_p});
      pulse_clear_chk();
    end

    // ---- randomized frames against the reference model ----
    for (int g = 0; g < 30; g++) begin
      m    = rand_mask();
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        do_frame(m);
        check("rnd_onehot", {16'd0, kp.onehot},    {16'd0, m_onehot});
        check("rnd_pulse",  {31'd0, kp.key_pulse}, {31'd0, m_pulse});
        pulse_clear_chk();
      end
    end

    // ---- asynchronous reset mid-frame with a key accepted ----
    for (int h = 0; h < 4; h++) begin
      do_frame(16'h0040);
      check("pre_rst_model", {16'd0, kp.onehot}, {16'd0, m_onehot});
    end
    check("pre_rst_onehot", {16'd0, kp.onehot}, 32'h0000_0040);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_col",    {28'd0, kp.col},        32'h0000_000E);
    check("arst_onehot", {16'd0, kp.onehot},     32'd0);
    check("arst_pulse",  {31'd0, kp.key_pulse},  32'd0);
    check("arst_tick",   {31'd0, kp.frame_tick}, 32'd0);
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // the partial frame is gone: a whole new frame must elapse before EVAL
    k  = 0;
    ok = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (kp.frame_tick) begin
        ok = 1'b1;
        break;
      end
      k++;
      @(negedge clk);
    end
    check("post_rst_tick_found", {31'd0, ok}, 32'd1);
    check("post_rst_tick_pos",   k,           32'd16);
    check("post_rst_onehot",     {16'd0, kp.onehot}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
